// File: rtl/conv2_relu_maxpool.sv
// Bias + ReLU + 12-bit saturation followed by 2x2/stride-2 max pooling on a
// raster-ordered conv2 result stream for a single output channel.
module conv2_relu_maxpool #(
    parameter int                     IN_W   = 14,
    parameter int                     OUT_W  = 12,
    parameter int                     WIDTH  = 8,
    parameter int                     HEIGHT = 8,
    parameter logic signed [IN_W-1:0] BIAS   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic signed [IN_W-1:0]  data_in,
    output logic        [OUT_W-1:0] data_out,
    output logic                    valid_out,
    output logic                    frame_done
);

    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);
    localparam int LB_D  = WIDTH / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);

    function automatic logic [OUT_W-1:0] umax(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [OUT_W-1:0] hold_q, hold_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             frame_done_q, frame_done_d;

    logic [OUT_W-1:0] linebuf [LB_D];
    logic [LB_AW-1:0] lb_idx;
    logic [OUT_W-1:0] lb_rdata;
    logic             lb_we;
    logic [OUT_W-1:0] lb_wdata;

    logic signed [IN_W:0] sum;
    logic [OUT_W-1:0]     relu;
    logic [OUT_W-1:0]     pair_max;
    logic                 last_col;
    logic                 last_row;

    // One extra bit of headroom makes the bias add overflow-free.
    always_comb begin
        sum = $signed({data_in[IN_W-1], data_in}) + $signed({BIAS[IN_W-1], BIAS});
        if (sum[IN_W]) begin
            relu = '0;
        end else if (sum > SAT_MAX) begin
            relu = SAT_MAX[OUT_W-1:0];
        end else begin
            relu = sum[OUT_W-1:0];
        end
    end

    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rdata = linebuf[lb_idx];
    assign pair_max = umax(hold_q, relu);
    assign last_col = (col_q == CW'(WIDTH - 1));
    assign last_row = (row_q == RW'(HEIGHT - 1));

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        lb_wdata     = pair_max;

        if (valid_in) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                hold_d = relu;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                data_out_d   = umax(lb_rdata, pair_max);
                valid_out_d  = 1'b1;
                frame_done_d = last_row && last_col;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of the others regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the line buffer is deliberately not reset; each entry is written on
    // an even row before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= lb_wdata;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2_relu_maxpool.sv
// Scoreboard bench: two instances (bias 0 and bias -5) share one randomized
// stream; a frame-level reference model predicts every pooled output.
`timescale 1ns/100ps
module tb_conv2_relu_maxpool;

    localparam int IN_W = 14, OUT_W = 12, W = 8, H = 8;
    localparam int NPIX = W * H;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   valid_in = 1'b0;
    logic signed [IN_W-1:0] data_in = '0;
    logic [OUT_W-1:0]       data_out0, data_out1;
    logic                   valid_out0, valid_out1, frame_done0, frame_done1;

    always #5 clk = ~clk;

    conv2_relu_maxpool #(.IN_W(IN_W), .OUT_W(OUT_W), .WIDTH(W), .HEIGHT(H),
                         .BIAS(14'sd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .data_out(data_out0), .valid_out(valid_out0), .frame_done(frame_done0));

    conv2_relu_maxpool #(.IN_W(IN_W), .OUT_W(OUT_W), .WIDTH(W), .HEIGHT(H),
                         .BIAS(-14'sd5)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .data_out(data_out1), .valid_out(valid_out1), .frame_done(frame_done1));

    typedef struct {
        int     val;
        bit     last;
        longint cyc;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    int     last_val [2];
    int     outcnt [2];
    int     donecnt [2];
    int     img0 [H][W];
    int     img1 [H][W];
    int     pix_idx = 0;
    int     fv [NPIX];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_r(input int x, input int bias);
        int s;
        s = x + bias;
        if (s < 0) return 0;
        if (s > (1 << (OUT_W - 1)) - 1) return (1 << (OUT_W - 1)) - 1;
        return s;
    endfunction

    // Reference model: store the ReLU'd image and, on completing a window,
    // push the maximum of its four pixels.
    task automatic model_pixel(input int v);
        int   r, c;
        exp_t e;
        r = pix_idx / W;
        c = pix_idx % W;
        img0[r][c] = ref_r(v, 0);
        img1[r][c] = ref_r(v, -5);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.last = (pix_idx == NPIX - 1);
            e.cyc  = cyc + 1;
            e.val  = img0[r-1][c-1];
            if (img0[r-1][c] > e.val) e.val = img0[r-1][c];
            if (img0[r][c-1] > e.val) e.val = img0[r][c-1];
            if (img0[r][c]   > e.val) e.val = img0[r][c];
            q0.push_back(e);
            e.val = img1[r-1][c-1];
            if (img1[r-1][c] > e.val) e.val = img1[r-1][c];
            if (img1[r][c-1] > e.val) e.val = img1[r][c-1];
            if (img1[r][c]   > e.val) e.val = img1[r][c];
            q1.push_back(e);
        end
        pix_idx = (pix_idx + 1) % NPIX;
    endtask

    task automatic mon(input int k, input logic v, input logic [OUT_W-1:0] d, input logic f);
        exp_t e;
        if (v) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out dut%0d: got %0d, expected no output", k, d);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("data dut%0d", k), 32'(d), 32'(e.val));
                check($sformatf("frame_done dut%0d", k), 32'(f), 32'(e.last));
                check($sformatf("latency dut%0d", k), 32'(cyc), 32'(e.cyc));
            end
            last_val[k] = int'(d);
            outcnt[k]++;
            if (f) donecnt[k]++;
        end else begin
            check($sformatf("hold dut%0d", k), 32'(d), 32'(last_val[k]));
            check($sformatf("done_idle dut%0d", k), 32'(f), 32'(0));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, valid_out0, data_out0, frame_done0);
            mon(1, valid_out1, data_out1, frame_done1);
        end
    end

    task automatic drive_pixel(input int v, input int gap);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        data_in  = IN_W'(v);
        model_pixel(v);
        repeat (gap) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            data_in  = IN_W'($urandom);
        end
    endtask

    task automatic end_stream();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random 0..3 idle cycles
    task automatic send_pixels(input int n, input int gap_mode);
        for (int i = 0; i < n; i++) begin
            drive_pixel(fv[i], (gap_mode == 0) ? 0 :
                               (gap_mode == 1) ? 1 : int'($urandom_range(0, 3)));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_queues_empty", 32'(q0.size() + q1.size()), 32'(0));
    endtask

    task automatic run_frames(input string name, input int nframes, input int gap_mode,
                              input int fill);
        int o0, o1, d0, d1;
        o0 = outcnt[0]; o1 = outcnt[1]; d0 = donecnt[0]; d1 = donecnt[1];
        for (int f = 0; f < nframes; f++) begin
            if (fill == 1) begin
                for (int i = 0; i < NPIX; i++) fv[i] = int'($urandom_range(0, 16383)) - 8192;
            end
            send_pixels(NPIX, gap_mode);
        end
        end_stream();
        drain();
        repeat (2) @(negedge clk);
        check({name, " outputs dut0"}, 32'(outcnt[0] - o0), 32'(16 * nframes));
        check({name, " outputs dut1"}, 32'(outcnt[1] - o1), 32'(16 * nframes));
        check({name, " frame_done dut0"}, 32'(donecnt[0] - d0), 32'(nframes));
        check({name, " frame_done dut1"}, 32'(donecnt[1] - d1), 32'(nframes));
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) fv[i] = i;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < NPIX; i++) fv[i] = v;
    endtask

    task automatic fill_sat();
        int p;
        fill_const(0);
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                p = int'($urandom_range(0, 3));
                fv[(2 * wr + p / 2) * W + 2 * wc + p % 2] = 8191;
            end
        end
    endtask

    task automatic reset_model();
        q0.delete();
        q1.delete();
        pix_idx     = 0;
        last_val[0] = 0;
        last_val[1] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        last_val = '{0, 0};
        outcnt   = '{0, 0};
        donecnt  = '{0, 0};

        // Reset held with valid_in high must be ignored.
        valid_in = 1'b1;
        data_in  = 14'sd500;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid_out dut0", 32'(valid_out0), 32'(0));
        check("reset data_out dut0", 32'(data_out0), 32'(0));
        check("reset frame_done dut0", 32'(frame_done0), 32'(0));
        check("reset valid_out dut1", 32'(valid_out1), 32'(0));
        check("reset data_out dut1", 32'(data_out1), 32'(0));
        check("reset frame_done dut1", 32'(frame_done1), 32'(0));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        #2;
        rst_n = 1'b1;

        fill_ramp();
        run_frames("ramp", 1, 0, 0);

        fill_const(-100);
        run_frames("neg100", 1, 0, 0);
        fill_const(3);
        run_frames("const3", 1, 0, 0);

        fill_sat();
        run_frames("saturate", 1, 0, 0);
        fill_const(-8192);
        run_frames("min_input", 1, 0, 0);

        fill_ramp();
        run_frames("gapped_ramp", 1, 1, 0);

        // Reset pulse between clock edges after 20 ramp pixels.
        send_pixels(20, 0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        #1;
        rst_n = 1'b0;
        reset_model();
        #1;
        check("midreset data_out dut0", 32'(data_out0), 32'(0));
        check("midreset valid_out dut0", 32'(valid_out0), 32'(0));
        check("midreset data_out dut1", 32'(data_out1), 32'(0));
        rst_n = 1'b1;
        run_frames("after_reset", 2, 0, 0);

        run_frames("random", 3, 2, 1);
        run_frames("random_b2b", 2, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
